vram_arbiter: RTL and testbench

Arbitrates the single-port 64K×12 video RAM between three requesters:
- the display controller's pixel fetch, at fixed priority;
- a buffered pixel-write port, used by the drawing/cursor logic;
- a built-in full-screen clear engine.

It sits between the 256×256 frame buffer and everything that touches it, so the display path never stalls while writers share the leftover cycles.

---
 rtl/vram_pkg.sv | 15 +
 rtl/vram_arbiter_fifo.sv | 53 +++++
 rtl/vram_arbiter.sv | 118 +++++++++++
 tb/tb_vram_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared video definitions: frame-buffer geometry, pixel format and the
// arbiter FSM state encoding.
package vram_pkg;

   localparam int unsigned VID_ADDR_W = 16;
   localparam int unsigned VID_DATA_W = 12;
   localparam int unsigned FRAME_W    = 256;
   localparam int unsigned FRAME_H    = 256;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } arb_state_e;

endpackage

// File: rtl/vram_arbiter_fifo.sv
// Count-based synchronous FIFO used to buffer pixel writes while the RAM
// port is owned by the display fetch or the clear engine.
module sync_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 28
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_ok, pop_ok;

   always_comb begin
      full_o  = (count_q == (PTR_W+1)'(DEPTH));
      empty_o = (count_q == '0);
      push_ok = push_i && !full_o;
      pop_ok  = pop_i && !empty_o;
      rdata_o = mem_q[rd_ptr_q];
   end

   // Depth is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: display fetch has absolute priority, then the
// full-screen clear engine, then buffered pixel writes.
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned ADDR_W     = VID_ADDR_W,
   parameter int unsigned DATA_W     = VID_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              clr_start,
   input  logic [DATA_W-1:0] clr_color,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   arb_state_e         state_q;
   logic [ADDR_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0]  color_q;
   logic               rd_valid_q, clr_done_q;

   logic               rd_go, push, pop, fifo_full, fifo_empty;
   logic [ADDR_W+DATA_W-1:0] fifo_head;

   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ADDR_W + DATA_W)
   ) u_wr_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i ({wr_addr, wr_data}),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Reset is folded into the read request so the RAM port is quiet while held.
   always_comb begin
      rd_go     = rd_en && rst;
      wr_ready  = rst && !fifo_full;
      push      = wr_valid && wr_ready;
      pop       = 1'b0;
      cnt_d     = cnt_q + 1'b1;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (rd_go) begin
         ram_en   = 1'b1;
         ram_addr = rd_addr;
      end else if (state_q == CLEAR) begin
         ram_en    = 1'b1;
         ram_we    = 1'b1;
         ram_addr  = cnt_q;
         ram_wdata = color_q;
      end else if (!fifo_empty) begin
         ram_en    = 1'b1;
         ram_we    = 1'b1;
         ram_addr  = fifo_head[ADDR_W+DATA_W-1:DATA_W];
         ram_wdata = fifo_head[DATA_W-1:0];
         pop       = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         color_q    <= '0;
         rd_valid_q <= 1'b0;
         clr_done_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_go;
         clr_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (clr_start) begin
                  state_q <= CLEAR;
                  cnt_q   <= '0;
                  color_q <= clr_color;
               end
            end
            CLEAR: begin
               if (!rd_go) begin
                  cnt_q <= cnt_d;
                  if (cnt_q == '1) begin
                     state_q    <= IDLE;
                     clr_done_q <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rd_data  = ram_rdata;
   assign rd_valid = rd_valid_q;
   assign clr_busy = (state_q == CLEAR);
   assign clr_done = clr_done_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised bench for vram_arbiter against a queue-based reference model and
// a behavioural single-port RAM with one-cycle synchronous read.
module tb_vram_arbiter;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 16;
   localparam int unsigned DW    = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          rd_en = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          wr_valid = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_ready;
   logic          clr_start = 1'b0;
   logic [DW-1:0] clr_color = '0;
   logic          clr_busy, clr_done;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata = '0;

   always #5 clk = ~clk;

   vram_arbiter #(
      .FIFO_DEPTH (DEPTH),
      .ADDR_W     (AW),
      .DATA_W     (DW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .wr_valid  (wr_valid),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .clr_start (clr_start),
      .clr_color (clr_color),
      .clr_busy  (clr_busy),
      .clr_done  (clr_done),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   logic [DW-1:0] ram [65536];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) ram[ram_addr] <= ram_wdata;
         else        ram_rdata     <= ram[ram_addr];
      end
   end

   // Reference model: expected RAM contents, pending-write queue, clear progress.
   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   logic [DW-1:0] mdl_mem [65536];
   wr_t           wq[$];
   bit            m_busy, m_done, m_rv, m_pushed;
   logic [AW-1:0] m_idx;
   logic [DW-1:0] m_color, m_rdata;

   int total = 0;
   int bad   = 0;
   int busy_cyc = 0, rd_busy_cyc = 0, done_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      wq.delete();
      m_busy = 0; m_done = 0; m_rv = 0; m_pushed = 0;
      m_idx = '0; m_color = '0; m_rdata = '0;
   endtask

   task automatic step();
      logic          e_en, e_we;
      logic [AW-1:0] e_a;
      logic [DW-1:0] e_d;
      bit            rdy, busy_pre;
      @(negedge clk);
      if (!rst) begin
         check("rst_ram_en", ram_en, 0);
         check("rst_ram_we", ram_we, 0);
         check("rst_rd_valid", rd_valid, 0);
         check("rst_clr_busy", clr_busy, 0);
         check("rst_clr_done", clr_done, 0);
         check("rst_wr_ready", wr_ready, 0);
      end else begin
         e_en = 0; e_we = 0; e_a = '0; e_d = '0;
         if (rd_en) begin
            e_en = 1; e_a = rd_addr;
         end else if (m_busy) begin
            e_en = 1; e_we = 1; e_a = m_idx; e_d = m_color;
         end else if (wq.size() > 0) begin
            e_en = 1; e_we = 1; e_a = wq[0].a; e_d = wq[0].d;
         end
         check("ram_en", ram_en, e_en);
         check("ram_we", ram_we, e_we);
         if (e_en) check("ram_addr", ram_addr, e_a);
         if (e_we) check("ram_wdata", ram_wdata, e_d);
         check("wr_ready", wr_ready, (wq.size() < DEPTH));
         check("rd_valid", rd_valid, m_rv);
         if (m_rv) check("rd_data", rd_data, m_rdata);
         check("clr_busy", clr_busy, m_busy);
         check("clr_done", clr_done, m_done);
         if (clr_busy) begin
            busy_cyc++;
            if (rd_en) rd_busy_cyc++;
         end
         if (clr_done) done_cnt++;
      end
      @(posedge clk);
      if (!rst) begin
         model_reset();
      end else begin
         rdy      = (wq.size() < DEPTH);
         busy_pre = m_busy;
         m_done   = 0;
         m_rv     = rd_en;
         if (rd_en) begin
            m_rdata = mdl_mem[rd_addr];
         end else if (m_busy) begin
            mdl_mem[m_idx] = m_color;
            if (m_idx == 16'hFFFF) begin
               m_busy = 0;
               m_done = 1;
            end
            m_idx = m_idx + 1'b1;
         end else if (wq.size() > 0) begin
            mdl_mem[wq[0].a] = wq[0].d;
            void'(wq.pop_front());
         end
         m_pushed = wr_valid && rdy;
         if (m_pushed) wq.push_back('{a: wr_addr, d: wr_data});
         if (!busy_pre && clr_start) begin
            m_busy  = 1;
            m_idx   = '0;
            m_color = clr_color;
         end
      end
      #1;
   endtask

   initial begin
      int            n;
      logic [DW-1:0] v;
      model_reset();
      for (int i = 0; i < 65536; i++) begin
         v = DW'($urandom);
         ram[i]     = v;
         mdl_mem[i] = v;
      end
      ram[16'h1234]     = 12'hABC;
      mdl_mem[16'h1234] = 12'hABC;

      // Held in reset
      repeat (3) step();
      rst = 1'b1;

      // Continuous display fetch of a known pixel
      rd_en = 1'b1; rd_addr = 16'h1234;
      repeat (20) step();

      // Four writes while the display owns the port, then drain
      for (int i = 0; i < 4; i++) begin
         rd_addr  = AW'($urandom);
         wr_valid = 1'b1;
         wr_addr  = AW'(i);
         wr_data  = DW'(12'h111 * (i + 1));
         step();
      end
      wr_valid = 1'b0;
      step();
      check("wr_full", wr_ready, 0);
      rd_en = 1'b0;
      repeat (6) step();
      check("wr_ready_back", wr_ready, 1);
      for (int i = 0; i < 4; i++) check("fifo_commit", ram[i], DW'(12'h111 * (i + 1)));

      // Random mixed reads and held writes
      for (int c = 0; c < 2000; c++) begin
         rd_en   = ($urandom_range(0, 1) == 1);
         rd_addr = AW'($urandom);
         if (!wr_valid || m_pushed) begin
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_addr  = AW'($urandom);
            wr_data  = DW'($urandom);
         end
         step();
      end
      rd_en = 1'b0; wr_valid = 1'b0;
      repeat (8) step();

      // Full clear with sparse reads, a write landing mid-clear, ignored restarts
      busy_cyc = 0; rd_busy_cyc = 0; done_cnt = 0;
      clr_start = 1'b1; clr_color = 12'h0F0;
      step();
      clr_start = 1'b0;
      n = 0;
      while (m_busy && n < 80000) begin
         rd_en     = ($urandom_range(0, 99) < 3);
         rd_addr   = AW'($urandom);
         wr_valid  = (n == 10);
         wr_addr   = 16'h8080;
         wr_data   = 12'hF00;
         clr_start = (m_idx < 16'hF000) && ($urandom_range(0, 999) == 0);
         clr_color = DW'($urandom);
         step();
         n++;
      end
      check("clr_timeout", n < 80000, 1);
      rd_en = 1'b0; wr_valid = 1'b0; clr_start = 1'b0;
      repeat (4) step();
      check("clr_len", busy_cyc, 65536 + rd_busy_cyc);
      check("clr_done_cnt", done_cnt, 1);
      check("px_8080", ram[16'h8080], 12'hF00);
      check("px_807f", ram[16'h807F], 12'h0F0);
      check("px_8081", ram[16'h8081], 12'h0F0);
      check("px_0000", ram[16'h0000], 12'h0F0);
      check("px_ffff", ram[16'hFFFF], 12'h0F0);
      foreach (rd_addr[i]) ;
      rd_en = 1'b1;
      rd_addr = 16'h8080; step();
      rd_addr = 16'h807F; step();
      rd_addr = 16'h8081; step();
      rd_en = 1'b0; step();
      n = 0;
      for (int i = 0; i < 65536; i++) if (ram[i] !== mdl_mem[i]) n++;
      check("mem_sweep", n, 0);

      // Reset mid-clear with two buffered writes
      clr_start = 1'b1; clr_color = 12'h123;
      step();
      clr_start = 1'b0;
      repeat (100) step();
      rd_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         rd_addr  = AW'($urandom);
         wr_valid = 1'b1;
         wr_addr  = AW'(16'h4000 + i);
         wr_data  = 12'h777;
         step();
      end
      rd_en = 1'b0; wr_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("arst_ram_en", ram_en, 0);
      check("arst_ram_we", ram_we, 0);
      check("arst_clr_busy", clr_busy, 0);
      check("arst_rd_valid", rd_valid, 0);
      check("arst_clr_done", clr_done, 0);
      model_reset();
      repeat (2) step();
      rst = 1'b1;
      done_cnt = 0;
      repeat (50) step();
      check("no_done_after_rst", done_cnt, 0);
      check("no_commit_4000", ram[16'h4000] === 12'h777, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
